// File: rtl/divided_tick_timer.sv
// Day/hour timer clocked from a selectable tap of a free-running divider bus.
// Optional macro TAP_CHANGE_MASK_EN suppresses edge detection in the cycle tap_sel changes.
module divided_tick_timer #(
  parameter int unsigned DAY_HOURS      = 8,
  parameter int unsigned TICKS_PER_HOUR = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] divided_clocks,
  input  logic [4:0]  tap_sel,
  input  logic        start,
  input  logic        hold,
  output logic        tick,
  output logic [3:0]  hour,
  output logic        hour_pulse,
  output logic        running,
  output logic        day_done
);

  localparam logic [3:0] LastHour = 4'(DAY_HOURS - 1);
  localparam logic [7:0] LastSub  = 8'(TICKS_PER_HOUR - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] hour_q, hour_d;
  logic [7:0] sub_q, sub_d;
  logic       tap_q, tap_d;
  logic       tick_q, tick_d;
  logic       hour_pulse_q, hour_pulse_d;
  logic       running_q, running_d;
  logic       day_done_q, day_done_d;
  logic       tap_cur;
  logic       edge_det;
  logic       tap_changed;

`ifdef TAP_CHANGE_MASK_EN
  logic [4:0] tap_sel_q;
  assign tap_changed = (tap_sel != tap_sel_q);
`else
  assign tap_changed = 1'b0;
`endif

  always_comb begin
    tap_cur  = divided_clocks[tap_sel];
    tap_d    = tap_cur;
    edge_det = tap_cur & ~tap_q & ~tap_changed;
    tick_d   = edge_det;

    state_d      = state_q;
    hour_d       = hour_q;
    sub_d        = sub_q;
    hour_pulse_d = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        // A tick coinciding with start is dropped: counters restart from zero.
        if (start) begin
          state_d = StRun;
          hour_d  = 4'd0;
          sub_d   = 8'd0;
        end
      end
      StRun: begin
        if (hold) begin
          state_d = StPause;
        end else if (tick_q) begin
          if (sub_q == LastSub) begin
            sub_d = 8'd0;
            if (hour_q == LastHour) begin
              state_d = StDone;
            end else begin
              hour_d       = hour_q + 4'd1;
              hour_pulse_d = 1'b1;
            end
          end else begin
            sub_d = sub_q + 8'd1;
          end
        end
      end
      StPause: begin
        if (!hold) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    running_d  = (state_d == StRun);
    day_done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      hour_q       <= 4'd0;
      sub_q        <= 8'd0;
      tap_q        <= 1'b0;
      tick_q       <= 1'b0;
      hour_pulse_q <= 1'b0;
      running_q    <= 1'b0;
      day_done_q   <= 1'b0;
`ifdef TAP_CHANGE_MASK_EN
      // Track the live select so the first cycle after reset is not masked.
      tap_sel_q    <= tap_sel;
`endif
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      sub_q        <= sub_d;
      tap_q        <= tap_d;
      tick_q       <= tick_d;
      hour_pulse_q <= hour_pulse_d;
      running_q    <= running_d;
      day_done_q   <= day_done_d;
`ifdef TAP_CHANGE_MASK_EN
      tap_sel_q    <= tap_sel;
`endif
    end
  end

  assign tick       = tick_q;
  assign hour       = hour_q;
  assign hour_pulse = hour_pulse_q;
  assign running    = running_q;
  assign day_done   = day_done_q;

endmodule

// File: tb/tb_divided_tick_timer.sv
// Bench for divided_tick_timer: directed scenarios plus random hold/start/tap/reset traffic,
// checked every cycle against a tick-count model of the simulated day.
module tb_divided_tick_timer;

  localparam int DAY   = 8;
  localparam int TPH   = 4;
  localparam int TOTAL = DAY * TPH;
  localparam int MI = 0, MR = 1, MP = 2, MD = 3;

  logic        clk;
  logic        reset;
  logic [31:0] divided_clocks;
  logic [4:0]  tap_sel;
  logic        start;
  logic        hold;
  logic        tick;
  logic [3:0]  hour;
  logic        hour_pulse;
  logic        running;
  logic        day_done;

  logic [31:0] dcnt;
  int          checks;
  int          errors;
  int          hp_seen;

  // Reference model: day progress kept as a count of accepted ticks.
  int          m_st;
  int          m_cnt;
  logic        m_tap;
  logic        m_tick;
  logic        m_hp;
`ifdef TAP_CHANGE_MASK_EN
  logic [4:0]  m_tsq;
`endif

  divided_tick_timer #(
    .DAY_HOURS     (DAY),
    .TICKS_PER_HOUR(TPH)
  ) dut (
    .clock         (clk),
    .reset         (reset),
    .divided_clocks(divided_clocks),
    .tap_sel       (tap_sel),
    .start         (start),
    .hold          (hold),
    .tick          (tick),
    .hour          (hour),
    .hour_pulse    (hour_pulse),
    .running       (running),
    .day_done      (day_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_hour();
    return (m_cnt >= TOTAL) ? DAY - 1 : m_cnt / TPH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic sel;
    logic edg;
    logic hp;
    if (reset) begin
      m_st   = MI;
      m_cnt  = 0;
      m_tap  = 1'b0;
      m_tick = 1'b0;
      m_hp   = 1'b0;
`ifdef TAP_CHANGE_MASK_EN
      m_tsq  = tap_sel;
`endif
    end else begin
      sel = divided_clocks[tap_sel];
      edg = sel && !m_tap;
`ifdef TAP_CHANGE_MASK_EN
      if (tap_sel != m_tsq) edg = 1'b0;
      m_tsq = tap_sel;
`endif
      m_tap = sel;
      hp    = 1'b0;
      case (m_st)
        MI, MD: if (start) begin m_st = MR; m_cnt = 0; end
        MR: begin
          if (hold) m_st = MP;
          else if (m_tick) begin
            m_cnt++;
            if (m_cnt == TOTAL) m_st = MD;
            else if (m_cnt % TPH == 0) hp = 1'b1;
          end
        end
        default: if (!hold) m_st = MR;
      endcase
      m_tick = edg;
      m_hp   = hp;
    end
  endtask

  task automatic check_outputs();
    chk("tick", 32'(tick), 32'(m_tick));
    chk("hour", 32'(hour), 32'(exp_hour()));
    chk("hour_pulse", 32'(hour_pulse), 32'(m_hp));
    chk("running", 32'(running), 32'(m_st == MR));
    chk("day_done", 32'(day_done), 32'(m_st == MD));
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    dcnt++;
    divided_clocks = dcnt;
  endtask

  initial begin
    checks = 0; errors = 0; hp_seen = 0;
    m_st = MI; m_cnt = 0; m_tap = 1'b0; m_tick = 1'b0; m_hp = 1'b0;
`ifdef TAP_CHANGE_MASK_EN
    m_tsq = 5'd0;
`endif
    dcnt = 32'd0; divided_clocks = 32'd0;
    reset = 1'b1; tap_sel = 5'd0; start = 1'b0; hold = 1'b0;

    // Reset state
    tick_clk(); tick_clk();
    chk("rst_hour", 32'(hour), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);

    // Start on tap 0: hour 0 -> 1 after four ticks with a single hour_pulse
    reset = 1'b0; start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int i = 0; i < 40 && exp_hour() != 1; i++) begin
      tick_clk();
      hp_seen += 32'(hour_pulse);
    end
    chk("first_hour", 32'(hour), 32'd1);
    chk("first_hour_pulses", 32'(hp_seen), 32'd1);
    chk("first_running", 32'(running), 32'd1);

    // Full day on tap 1 ends in DONE at the last hour, further ticks ignored
    tap_sel = 5'd1;
    for (int i = 0; i < 400 && m_st != MD; i++) tick_clk();
    chk("done_flag", 32'(day_done), 32'd1);
    chk("done_hour", 32'(hour), 32'(DAY - 1));
    chk("done_running", 32'(running), 32'd0);
    for (int i = 0; i < 20; i++) tick_clk();
    chk("done_hour_held", 32'(hour), 32'(DAY - 1));

    // Restart from DONE while a tick is present: that tick is not counted
    tap_sel = 5'd0;
    for (int i = 0; i < 10 && tick !== 1'b1; i++) tick_clk();
    chk("restart_tick_seen", 32'(tick), 32'd1);
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    chk("restart_running", 32'(running), 32'd1);
    chk("restart_hour", 32'(hour), 32'd0);

    // Pause at hour 2 sub 1 for 20 clocks, then resume
    for (int i = 0; i < 100 && !(m_st == MR && m_cnt == 2 * TPH + 1); i++) tick_clk();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) tick_clk();
    chk("pause_running", 32'(running), 32'd0);
    chk("pause_hour", 32'(hour), 32'd2);
    hold = 1'b0;
    for (int i = 0; i < 40 && exp_hour() != 3; i++) tick_clk();
    chk("resume_hour", 32'(hour), 32'd3);

    // Mid-hour reset at hour 5
    for (int i = 0; i < 100 && !(m_st == MR && m_cnt == 5 * TPH + 2); i++) tick_clk();
    chk("pre_reset_hour", 32'(hour), 32'd5);
    reset = 1'b1;
    tick_clk();
    reset = 1'b0;
    chk("midreset_hour", 32'(hour), 32'd0);
    chk("midreset_running", 32'(running), 32'd0);
    chk("midreset_tick", 32'(tick), 32'd0);
    for (int i = 0; i < 8; i++) tick_clk();
    chk("idle_stays", 32'(running), 32'd0);

    // Tap switch 3 -> 0 while bit0=1 and bit3=0
    start = 1'b1; tap_sel = 5'd3;
    tick_clk();
    start = 1'b0;
    for (int i = 0; i < 40 && !(divided_clocks[0] && !divided_clocks[3]); i++) tick_clk();
    tap_sel = 5'd0;
    tick_clk();
`ifdef TAP_CHANGE_MASK_EN
    chk("tap_switch_tick", 32'(tick), 32'd0);
`else
    chk("tap_switch_tick", 32'(tick), 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) tap_sel = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) divided_clocks = $urandom;
      tick_clk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divided_tick_timer.md
DIVIDED_TICK_TIMER -- requirements
Module: divided_tick_timer

Interface
REQ-001 SHALL have parameter DAY_HOURS, default 8, meaning simulated hours per day (legal 2..16).
REQ-002 SHALL have parameter TICKS_PER_HOUR, default 4, meaning selected-tap rising edges per simulated hour (legal 2..256).
REQ-003 SHALL have port clock  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port divided_clocks  input  32  free-running divider bus from the clock divider, bit n toggling every 2^n clocks.
REQ-006 SHALL have port tap_sel  input  5  index of divided_clocks bit used as time base.
REQ-007 SHALL have port start  input  1  level; begins a new day from IDLE or DONE.
REQ-008 SHALL have port hold  input  1  level; freezes time while high.
REQ-009 SHALL have port tick  output  1  one-cycle pulse per qualified rising edge of the selected tap.
REQ-010 SHALL have port hour  output  4  current simulated hour, 0..DAY_HOURS-1.
REQ-011 SHALL have port hour_pulse  output  1  one-cycle pulse when hour advances.
REQ-012 SHALL have port running  output  1  high in RUN state only.
REQ-013 SHALL have port day_done  output  1  high in DONE state only.

Function
REQ-014 SHALL register the selected tap as tap_q each cycle; edge = divided_clocks[tap_sel] & ~tap_q.
REQ-015 SHALL drive tick registered: high exactly one cycle after the cycle an edge is detected, in every state.
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 IDLE: start=1 -> RUN, hour and sub-count cleared to 0; otherwise stay.
REQ-018 RUN: hold=1 -> PAUSE; else each tick increments sub-count.
REQ-019 PAUSE: hold=0 -> RUN; ticks ignored, hour and sub-count held.
REQ-020 Sub-count reaching TICKS_PER_HOUR-1 on a tick SHALL wrap to 0, increment hour, and pulse hour_pulse in the same cycle hour updates.
REQ-021 A tick when hour=DAY_HOURS-1 and sub-count=TICKS_PER_HOUR-1 SHALL move to DONE with hour held at DAY_HOURS-1 (no wrap) and hour_pulse low.
REQ-022 DONE: start=1 -> RUN with counters cleared; otherwise stay; ticks ignored.
REQ-023 tick and hold in the same RUN cycle: hold wins, tick not counted.
REQ-024 start with a tick in the same cycle (IDLE/DONE): tick not counted; counting begins from the next tick.
REQ-025 start in RUN or PAUSE SHALL be ignored.
REQ-026 tap_sel change mid-run SHALL take effect the next cycle; at most one spurious edge may result (see REQ-031).

Reset
REQ-027 reset=1 SHALL force state IDLE, hour=0, sub-count=0, tap_q=0, tick=0, hour_pulse=0, running=0, day_done=0 on the next posedge.
REQ-028 reset SHALL override start, hold and any pending tick, including mid-hour in RUN.
REQ-029 First edge after reset release SHALL be qualified against tap_q=0 (a tap already high yields one tick).

Configuration
REQ-030 Macro TAP_CHANGE_MASK_EN SHALL select tap-change masking.
REQ-031 With TAP_CHANGE_MASK_EN defined: tap_sel registered; cycle where tap_sel differs from its registered value SHALL suppress edge detection (no tick) and reload tap_q from the new tap. Without it: no masking; a change may produce one extra tick.

Verification
REQ-032 Reset, tap_sel=0, start pulse, hold=0 -> tick every 2 clocks; hour 0->1 after 4 ticks with one hour_pulse; running=1.
REQ-033 Defaults, tap_sel=1 -> after 32 ticks day_done=1, hour=7, running=0; further ticks leave hour=7.
REQ-034 RUN at hour=2 sub-count=1, hold=1 for 20 clocks at tap_sel=0 -> state PAUSE, hour=2, sub-count=1 unchanged; hold=0 resumes counting.
REQ-035 Mid-hour reset in RUN at hour=5 -> next cycle hour=0, running=0, tick=0, state IDLE.
REQ-036 tap_sel switched 3->0 while bit0=1, bit3=0: with TAP_CHANGE_MASK_EN no tick that cycle; without it exactly one extra tick.
REQ-037 DONE, start asserted coincident with edge -> RUN, hour=0, sub-count=0, that edge not counted.
